// File: rtl/dac_write_scheduler.sv
// dac_write_scheduler: round-robin scheduler for the shared 16-bit parallel DAC bus.
// Latency: grant on the edge after req is seen in IDLE; the write takes SETUP+WE+HOLD (+LDAC) cycles; ack on the first cycle after HOLD.
// Backpressure: req is a level held until req_ack; a latched write always completes, and rst aborts it without an ack.
//
// Ports:
//   clk, rst        - block clock (rising edge), asynchronous active-high reset
//   req, req_data   - per-requester write request level and 16-bit code (slice i = bits [16i+15:16i])
//   req_ack         - one-cycle completion pulse for the granted requester
//   ldac_req        - single-cycle manual load request (only honoured when AUTO_LDAC = 0)
//   busy            - high whenever the sequencer is not in IDLE
//   we, ldac        - active-low DAC write enable and load strobes
//   dac_reset       - active-low DAC reset, driven low during the power-on sequence
//   dac_sel, to_daq - channel address and data bus of the current write
module dac_write_scheduler #(
  parameter int N_REQ     = 4,
  parameter int SETUP_CYC = 2,
  parameter int WE_CYC    = 3,
  parameter int HOLD_CYC  = 2,
  parameter int LDAC_CYC  = 3,
  parameter int RST_CYC   = 16,
  parameter int AUTO_LDAC = 1,
  localparam int SEL_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [16*N_REQ-1:0]    req_data,
  output logic [N_REQ-1:0]       req_ack,
  input  logic                   ldac_req,
  output logic                   busy,
  output logic                   we,
  output logic                   ldac,
  output logic                   dac_reset,
  output logic [SEL_W-1:0]       dac_sel,
  output logic [15:0]            to_daq
);

  localparam int CNT_W = 16;

  // Counter load value for a state lasting p cycles; 0 behaves like 1.
  function automatic logic [CNT_W-1:0] cyc_load(input int p);
    return (p <= 1) ? '0 : CNT_W'(p - 1);
  endfunction

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_LOAD
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    rr_q, rr_d;
  logic                pend_q, pend_d;
  logic                we_q, we_d;
  logic                ldac_q, ldac_d;
  logic                dac_reset_q, dac_reset_d;
  logic                busy_q, busy_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [15:0]         data_q, data_d;
  logic [N_REQ-1:0]    ack_q, ack_d;

  // Round-robin pick: prefer the lowest asserted request at or above the
  // pointer; if none, wrap to the lowest asserted request overall.
  logic [N_REQ-1:0]    rr_mask;
  logic [N_REQ-1:0]    req_hi;
  logic                gnt_found;
  logic [SEL_W-1:0]    gnt_idx;
  logic [15:0]         gnt_data;

  always_comb begin
    rr_mask   = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rr_mask[i] = (i >= int'(rr_q));
    end
    req_hi = req & rr_mask;
    // Descending scans so the lowest index is the one that sticks.
    if (req_hi != '0) begin
      gnt_found = 1'b1;
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (req_hi[i]) begin
          gnt_idx  = SEL_W'(i);
          gnt_data = req_data[16*i +: 16];
        end
      end
    end else if (req != '0) begin
      gnt_found = 1'b1;
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt_idx  = SEL_W'(i);
          gnt_data = req_data[16*i +: 16];
        end
      end
    end
  end

  // Manual load pending: includes a request arriving this very cycle so a
  // simultaneous ldac_req wins over a write request in IDLE.
  logic load_pend;

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : cnt_q;
    rr_d      = rr_q;
    sel_d     = sel_q;
    data_d    = data_q;
    ack_d     = '0;
    load_pend = (AUTO_LDAC == 0) && (pend_q || ldac_req);
    pend_d    = load_pend;

    case (state_q)
      S_INIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        // No arbitration while the previous ack is still on the bus.
        if (ack_q == '0) begin
          if (load_pend) begin
            state_d = S_LOAD;
            cnt_d   = cyc_load(LDAC_CYC);
            pend_d  = 1'b0;
          end else if (gnt_found) begin
            state_d = S_SETUP;
            cnt_d   = cyc_load(SETUP_CYC);
            sel_d   = gnt_idx;
            data_d  = gnt_data;
            if (int'(gnt_idx) == N_REQ - 1) begin
              rr_d = '0;
            end else begin
              rr_d = gnt_idx + SEL_W'(1);
            end
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = cyc_load(WE_CYC);
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = cyc_load(HOLD_CYC);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          for (int i = 0; i < N_REQ; i++) begin
            ack_d[i] = (sel_q == SEL_W'(i));
          end
          if (AUTO_LDAC != 0) begin
            state_d = S_LOAD;
            cnt_d   = cyc_load(LDAC_CYC);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_LOAD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = cyc_load(RST_CYC);
      end
    endcase

    // Pin levels follow the next state so every output is a flop.
    we_d        = (state_d != S_STROBE);
    ldac_d      = (state_d != S_LOAD);
    dac_reset_d = (state_d != S_INIT);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      cnt_q       <= cyc_load(RST_CYC);
      rr_q        <= '0;
      pend_q      <= 1'b0;
      we_q        <= 1'b1;
      ldac_q      <= 1'b1;
      dac_reset_q <= 1'b0;
      busy_q      <= 1'b1;
      sel_q       <= '0;
      data_q      <= '0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      pend_q      <= pend_d;
      we_q        <= we_d;
      ldac_q      <= ldac_d;
      dac_reset_q <= dac_reset_d;
      busy_q      <= busy_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
    end
  end

  assign req_ack   = ack_q;
  assign busy      = busy_q;
  assign we        = we_q;
  assign ldac      = ldac_q;
  assign dac_reset = dac_reset_q;
  assign dac_sel   = sel_q;
  assign to_daq    = data_q;

endmodule
